// File: rtl/alu_pkg.sv
// Shared types for the multi-cycle ALU: operation encoding and FSM states.
package alu_pkg;

  typedef enum logic [3:0] {
    OpAdd    = 4'd0,
    OpSub    = 4'd1,
    OpSlt    = 4'd2,
    OpSltu   = 4'd3,
    OpAnd    = 4'd4,
    OpOr     = 4'd5,
    OpXor    = 4'd6,
    OpSll    = 4'd7,
    OpSrl    = 4'd8,
    OpSra    = 4'd9,
    OpMul    = 4'd10,
    OpMulhu  = 4'd11,
    OpDivu   = 4'd12,
    OpRemu   = 4'd13,
    OpRsvd14 = 4'd14,
    OpRsvd15 = 4'd15
  } alu_op_t;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StMul  = 2'd1,
    StDiv  = 2'd2,
    StDone = 2'd3
  } alu_state_t;

  // Ops that go through the iterative multiply/divide unit.
  function automatic logic op_is_mul(alu_op_t o);
    return (o == OpMul) || (o == OpMulhu);
  endfunction

  function automatic logic op_is_div(alu_op_t o);
    return (o == OpDivu) || (o == OpRemu);
  endfunction

endpackage

// File: rtl/alu_mc_muldiv.sv
// Iterative 1-bit-per-cycle shift-add multiplier and restoring divider.
// Both share one 2*WIDTH accumulator: {hi, lo} = {product hi, product lo}
// for multiply and {remainder, quotient} for divide.
module alu_mc_muldiv #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             div_mode,
  input  logic             sel_hi,
  input  logic [WIDTH-1:0] src0,
  input  logic [WIDTH-1:0] src1,
  output logic             done,
  output logic [WIDTH-1:0] res
);

  localparam int unsigned CntW = $clog2(WIDTH);

  logic               busy_q;
  logic               div_q;
  logic               hi_q;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q;
  logic [CntW-1:0]    cnt_q;

  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     trial;
  logic [WIDTH:0]     diff;
  logic               last;

  // One iteration step; done/res look at the post-step value so the final
  // iteration and the hand-off to the FSM share the same clock edge.
  always_comb begin
    sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    diff  = trial - {1'b0, opnd_q};
    if (div_q) begin
      // diff[WIDTH] set means the trial subtraction went negative: restore.
      if (!diff[WIDTH]) acc_d = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      else              acc_d = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end else begin
      acc_d = {sum, acc_q[WIDTH-1:1]};
    end
    last = busy_q && (cnt_q == CntW'(WIDTH - 1));
    done = last;
    res  = hi_q ? acc_d[2*WIDTH-1:WIDTH] : acc_d[WIDTH-1:0];
  end

  // Operand capture on start, then WIDTH iterations while busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      div_q  <= 1'b0;
      hi_q   <= 1'b0;
      acc_q  <= '0;
      opnd_q <= '0;
      cnt_q  <= '0;
    end else if (start) begin
      busy_q <= 1'b1;
      div_q  <= div_mode;
      hi_q   <= sel_hi;
      acc_q  <= {{WIDTH{1'b0}}, src0};
      opnd_q <= src1;
      cnt_q  <= '0;
    end else if (busy_q) begin
      acc_q <= acc_d;
      cnt_q <= cnt_q + CntW'(1);
      if (last) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshakes. Single-cycle ops are computed
// here; MUL/MULHU/DIVU/REMU are handed to alu_mc_muldiv.
module alu_mc
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] src0,
  input  logic [WIDTH-1:0] src1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  localparam int unsigned ShW = $clog2(WIDTH);

  alu_state_t       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q;
  logic             load_res;
  logic             accept;
  alu_op_t          op_e;
  logic [ShW-1:0]   shamt;
  logic [WIDTH-1:0] alu_res;
  logic             md_start;
  logic             md_done;
  logic [WIDTH-1:0] md_res;

  assign op_e     = alu_op_t'(op);
  assign shamt    = src1[ShW-1:0];
  assign in_ready = (state_q == StIdle) || ((state_q == StDone) && out_ready);
  assign accept   = in_valid && in_ready;

  // Single-cycle result. The DIVU/REMU entries are only used for a zero divisor.
  always_comb begin
    alu_res = '0;
    case (op_e)
      OpAdd:  alu_res = src0 + src1;
      OpSub:  alu_res = src0 - src1;
      OpSlt:  alu_res = {{(WIDTH-1){1'b0}}, $signed(src0) < $signed(src1)};
      OpSltu: alu_res = {{(WIDTH-1){1'b0}}, src0 < src1};
      OpAnd:  alu_res = src0 & src1;
      OpOr:   alu_res = src0 | src1;
      OpXor:  alu_res = src0 ^ src1;
      OpSll:  alu_res = src0 << shamt;
      OpSrl:  alu_res = src0 >> shamt;
      OpSra:  alu_res = $unsigned($signed(src0) >>> shamt);
      OpDivu: alu_res = '1;
      OpRemu: alu_res = src0;
      default: alu_res = '0;
    endcase
  end

  // Next-state logic and result load control.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    load_res = 1'b0;
    md_start = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (accept) begin
          if (op_is_mul(op_e)) begin
            state_d  = StMul;
            md_start = 1'b1;
          end else if (op_is_div(op_e) && (src1 != '0)) begin
            state_d  = StDiv;
            md_start = 1'b1;
          end else begin
            state_d  = StDone;
            result_d = alu_res;
            load_res = 1'b1;
          end
        end else if (state_q == StDone && out_ready) begin
          state_d = StIdle;
        end
      end
      StMul, StDiv: begin
        if (md_done) begin
          state_d  = StDone;
          result_d = md_res;
          load_res = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and registered result/zero flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load_res) begin
        result_q <= result_d;
        zero_q   <= (result_d == '0);
      end
    end
  end

  alu_mc_muldiv #(
    .WIDTH (WIDTH)
  ) u_muldiv (
    .clk      (clk),
    .rst      (rst),
    .start    (md_start),
    .div_mode (op_is_div(op_e)),
    .sel_hi   ((op_e == OpMulhu) || (op_e == OpRemu)),
    .src0     (src0),
    .src1     (src1),
    .done     (md_done),
    .res      (md_res)
  );

  assign out_valid = (state_q == StDone);
  assign result    = result_q;
  assign zero      = zero_q;

endmodule
